// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the 8N1 UART transceiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Common frame-phase encoding used by both the TX and RX machines
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE   = 16;  // ticks per bit period
    localparam int DATA_BITS    = 8;   // payload bits per frame
    localparam int START_SAMPLE = 8;   // tick at which the start bit is re-checked

    // sysclk cycles per oversample tick, rounded to nearest, never below 1
    function automatic int calc_div(input int clk_freq, input int baud);
        int div;
        div = (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return (div < 1) ? 1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Oversample tick generator. Counts 0..DIV-1 and emits a
//                one-cycle tick on the last count; a synchronous clear
//                restarts the count so the first tick lands DIV cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

    logic [c_CW-1:0] r_cnt;

    // Free-running divider, restartable by i_clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // No tick in the clearing cycle so the restarted period is a full DIV
    assign o_tick = !i_clear && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transceiver
//  Description : Full-duplex 8N1 UART with independent TX and RX machines.
//                TX: TX_SEND in idle latches TX_DATA and sends a 10-bit frame.
//                RX: synchronised line, start-bit glitch rejection, mid-bit
//                sampling, one-cycle RX_STATUS strobe on a valid stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    output logic       TX_STATUS,
    output logic       RX_STATUS,
    input  logic [7:0] TX_DATA,
    output logic [7:0] RX_DATA,
    output logic       UART_TX,
    input  logic       UART_RX,
    input  logic       TX_SEND
);

    localparam int         DIV         = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] c_SUB_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_MID_START = 4'(START_SAMPLE - 1);
    localparam logic [2:0] c_BIT_LAST  = 3'(DATA_BITS - 1);

    // ------------------------------------------------------------------ TX
    uart_state_e r_tx_state, w_tx_state_nxt;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;
    logic [3:0]  r_tx_sub;
    logic        w_tx_accept;
    logic        w_tx_tick;
    logic        w_tx_bit_end;

    uart_baud_gen #(.DIV(DIV)) u_tx_baud (
        .clk    (sysclk),
        .rst    (reset),
        .i_clear(w_tx_accept),
        .o_tick (w_tx_tick)
    );

    // TX next-state and line/status decode
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_accept    = 1'b0;
        w_tx_bit_end   = w_tx_tick && (r_tx_sub == c_SUB_LAST);
        UART_TX        = 1'b1;
        TX_STATUS      = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                TX_STATUS = 1'b1;
                if (TX_SEND) begin
                    w_tx_accept    = 1'b1;
                    w_tx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                UART_TX = 1'b0;
                if (w_tx_bit_end) w_tx_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                UART_TX = r_tx_shift[0];
                if (w_tx_bit_end && (r_tx_bit == c_BIT_LAST)) w_tx_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tx_bit_end) w_tx_state_nxt = ST_IDLE;
            end
            default: w_tx_state_nxt = ST_IDLE;
        endcase
    end

    // TX state register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) r_tx_state <= ST_IDLE;
        else       r_tx_state <= w_tx_state_nxt;
    end

    // TX shifter and bit/tick counters; busy requests never reach here
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_sub   <= '0;
        end else if (w_tx_accept) begin
            r_tx_shift <= TX_DATA;
            r_tx_bit   <= '0;
            r_tx_sub   <= '0;
        end else if (w_tx_tick && (r_tx_state != ST_IDLE)) begin
            r_tx_sub <= r_tx_sub + 1'b1;
            if (w_tx_bit_end && (r_tx_state == ST_DATA)) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ RX
    uart_state_e r_rx_state, w_rx_state_nxt;
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_bit;
    logic [3:0]  r_rx_sub;
    logic [7:0]  r_rx_data;
    logic        r_rx_status;
    logic        w_rx_start;
    logic        w_rx_tick;
    logic        w_rx_sample;
    logic        w_rx_load;

    uart_baud_gen #(.DIV(DIV)) u_rx_baud (
        .clk    (sysclk),
        .rst    (reset),
        .i_clear(w_rx_start),
        .o_tick (w_rx_tick)
    );

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= UART_RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX next-state: start check at mid start bit, then every full bit period
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_start     = 1'b0;
        w_rx_load      = 1'b0;
        w_rx_sample    = w_rx_tick &&
                         (r_rx_sub == ((r_rx_state == ST_START) ? c_MID_START : c_SUB_LAST));
        case (r_rx_state)
            ST_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_start     = 1'b1;
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_rx_sample) w_rx_state_nxt = r_rx_sync ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_rx_sample && (r_rx_bit == c_BIT_LAST)) w_rx_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_rx_sample) begin
                    w_rx_state_nxt = ST_IDLE;
                    w_rx_load      = r_rx_sync;
                end
            end
            default: w_rx_state_nxt = ST_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) r_rx_state <= ST_IDLE;
        else       r_rx_state <= w_rx_state_nxt;
    end

    // RX shifter, counters, output byte and one-cycle strobe
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_rx_shift  <= '0;
            r_rx_bit    <= '0;
            r_rx_sub    <= '0;
            r_rx_data   <= '0;
            r_rx_status <= 1'b0;
        end else begin
            r_rx_status <= w_rx_load;
            if (w_rx_load) r_rx_data <= r_rx_shift;
            if (w_rx_start) begin
                r_rx_sub <= '0;
                r_rx_bit <= '0;
            end else if (w_rx_tick && (r_rx_state != ST_IDLE)) begin
                r_rx_sub <= w_rx_sample ? 4'd0 : (r_rx_sub + 1'b1);
                if (w_rx_sample && (r_rx_state == ST_DATA)) begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 1'b1;
                end
            end
        end
    end

    assign RX_DATA   = r_rx_data;
    assign RX_STATUS = r_rx_status;

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_transceiver
//  Description : Self-checking bench for uart_transceiver at DIV=1
//                (16 sysclk cycles per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transceiver;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CYC  = 16;
    localparam int FRAME    = 10 * BIT_CYC;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       TX_STATUS, RX_STATUS, UART_TX;
    logic [7:0] RX_DATA;
    logic [7:0] TX_DATA;
    logic       TX_SEND;
    logic       rx_line;
    logic       loop_en;
    wire        uart_rx_w = loop_en ? UART_TX : rx_line;

    int total = 0;
    int bad   = 0;

    // Reference model state: expected received bytes and last good byte
    logic [7:0] exp_q[$];
    logic [7:0] rx_got[$];
    logic [7:0] last_good;
    int         rx_wide = 0;
    logic       prev_rs = 1'b0;

    uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .TX_STATUS(TX_STATUS),
        .RX_STATUS(RX_STATUS),
        .TX_DATA  (TX_DATA),
        .RX_DATA  (RX_DATA),
        .UART_TX  (UART_TX),
        .UART_RX  (uart_rx_w),
        .TX_SEND  (TX_SEND)
    );

    always #5 sysclk = ~sysclk;

    // Collect every strobe and the byte presented with it
    always @(negedge sysclk) begin
        if (RX_STATUS === 1'b1) begin
            rx_got.push_back(RX_DATA);
            if (prev_rs) rx_wide++;
        end
        prev_rs = (RX_STATUS === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ideal line waveform: one entry per sysclk cycle from the start bit on
    function automatic logic [FRAME-1:0] tx_wave(input logic [7:0] b);
        logic [9:0]       f;
        logic [FRAME-1:0] w;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < FRAME; k++) w[k] = f[k / BIT_CYC];
        return w;
    endfunction

    function automatic bit rx_matches();
        if (rx_got.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (rx_got[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Caller must be at a negedge; TX_SEND is raised immediately
    task automatic tx_frame(input logic [7:0] b, input int busy_at, input string tag);
        logic [FRAME-1:0] got, want;
        bit               low_ok;
        want   = tx_wave(b);
        got    = '0;
        low_ok = 1'b1;
        total++;
        if (TX_STATUS !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_before: TX_STATUS=%b want 1", tag, TX_STATUS);
        end
        TX_DATA = b;
        TX_SEND = 1'b1;
        @(posedge sysclk);
        #1;
        TX_SEND = 1'b0;
        TX_DATA = 8'($urandom);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge sysclk);
            got[k] = UART_TX;
            if (TX_STATUS !== 1'b0) low_ok = 1'b0;
            if (k == busy_at) begin
                TX_DATA = 8'hFF;
                TX_SEND = 1'b1;
            end else if (k == busy_at + 1) begin
                TX_SEND = 1'b0;
            end
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s waveform byte %h: got=%h want=%h", tag, b, got, want);
        end
        total++;
        if (!low_ok) begin
            bad++;
            $display("FAIL %s busy_status: TX_STATUS not 0 for all %0d cycles", tag, FRAME);
        end
        @(negedge sysclk);
        total++;
        if (TX_STATUS !== 1'b1 || UART_TX !== 1'b1) begin
            bad++;
            $display("FAIL %s end_idle: TX_STATUS=%b UART_TX=%b want 1 1", tag, TX_STATUS, UART_TX);
        end
    endtask

    // Drives one 10-bit frame; caller aligns to posedge+1 before the first call
    task automatic rx_drive(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (BIT_CYC) @(posedge sysclk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        TX_SEND = 1'b0;
        TX_DATA = 8'h00;
        rx_line = 1'b1;
        loop_en = 1'b0;
        #23;
        total++;
        if (UART_TX !== 1'b1) begin bad++; $display("FAIL reset_tx: got=%b want 1", UART_TX); end
        total++;
        if (TX_STATUS !== 1'b1) begin bad++; $display("FAIL reset_txstatus: got=%b want 1", TX_STATUS); end
        total++;
        if (RX_STATUS !== 1'b0) begin bad++; $display("FAIL reset_rxstatus: got=%b want 0", RX_STATUS); end
        total++;
        if (RX_DATA !== 8'h00) begin bad++; $display("FAIL reset_rxdata: got=%h want 00", RX_DATA); end
        last_good = 8'h00;
        @(negedge sysclk);
        reset = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic test_tx_frames();
        tx_frame(8'hA5, -1, "tx_a5");
        repeat (3) begin
            repeat (5) @(negedge sysclk);
            tx_frame(8'($urandom), -1, "tx_rand");
        end
    endtask

    task automatic test_tx_busy();
        bit idle_ok;
        repeat (3) @(negedge sysclk);
        tx_frame(8'hA5, 40, "tx_busy");
        idle_ok = 1'b1;
        repeat (48) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) idle_ok = 1'b0;
        end
        total++;
        if (!idle_ok) begin
            bad++;
            $display("FAIL tx_busy_no_second: line or status left idle, got=%b/%b want 1/1", UART_TX, TX_STATUS);
        end
    endtask

    task automatic test_back_to_back();
        tx_frame(8'($urandom), -1, "b2b_first");
        tx_frame(8'($urandom), -1, "b2b_second");
        repeat (5) @(negedge sysclk);
    endtask

    task automatic test_rx_back_to_back();
        logic [7:0] bytes[$];
        rx_got.delete();
        exp_q.delete();
        rx_wide = 0;
        bytes.push_back(8'($urandom));
        bytes.push_back(8'($urandom));
        bytes.push_back(8'h3C);
        bytes.push_back(8'hC3);
        @(posedge sysclk);
        #1;
        foreach (bytes[i]) begin
            rx_drive(bytes[i], 1'b1);
            exp_q.push_back(bytes[i]);
            last_good = bytes[i];
        end
        rx_line = 1'b1;
        repeat (40) @(posedge sysclk);
        @(negedge sysclk);
        total++;
        if (!rx_matches()) begin
            bad++;
            $display("FAIL rx_b2b: got %0d bytes (last %h) want %0d bytes (last %h)",
                     rx_got.size(), (rx_got.size() > 0) ? rx_got[$] : 8'hxx, exp_q.size(), last_good);
        end
        total++;
        if (rx_wide != 0) begin bad++; $display("FAIL rx_pulse_width: got %0d wide pulses want 0", rx_wide); end
        total++;
        if (RX_DATA !== 8'hC3) begin bad++; $display("FAIL rx_last: got=%h want c3", RX_DATA); end
    endtask

    task automatic test_rx_errors();
        logic [7:0] b;
        rx_got.delete();
        exp_q.delete();
        @(posedge sysclk);
        #1;
        rx_line = 1'b0;
        repeat (4) @(posedge sysclk);
        #1;
        rx_line = 1'b1;
        repeat (40) @(posedge sysclk);
        total++;
        if (rx_got.size() != 0) begin bad++; $display("FAIL rx_glitch: got %0d pulses want 0", rx_got.size()); end
        #1;
        rx_drive(8'h55, 1'b0);
        rx_line = 1'b1;
        repeat (40) @(posedge sysclk);
        @(negedge sysclk);
        total++;
        if (rx_got.size() != 0) begin bad++; $display("FAIL rx_framing: got %0d pulses want 0", rx_got.size()); end
        total++;
        if (RX_DATA !== last_good) begin bad++; $display("FAIL rx_framing_hold: got=%h want %h", RX_DATA, last_good); end
        b = 8'($urandom);
        @(posedge sysclk);
        #1;
        rx_drive(b, 1'b1);
        exp_q.push_back(b);
        last_good = b;
        repeat (30) @(posedge sysclk);
        @(negedge sysclk);
        total++;
        if (!rx_matches() || RX_DATA !== b) begin
            bad++;
            $display("FAIL rx_recover: got %0d bytes RX_DATA=%h want 1 byte %h", rx_got.size(), RX_DATA, b);
        end
    endtask

    task automatic test_loopback_reset();
        bool_check: begin end
        rx_got.delete();
        exp_q.delete();
        loop_en = 1'b1;
        repeat (4) @(negedge sysclk);
        tx_frame(8'h81, -1, "loop_81");
        exp_q.push_back(8'h81);
        repeat (10) @(negedge sysclk);
        total++;
        if (!rx_matches() || RX_DATA !== 8'h81) begin
            bad++;
            $display("FAIL loopback: got %0d bytes RX_DATA=%h want 1 byte 81", rx_got.size(), RX_DATA);
        end
        rx_got.delete();
        TX_DATA = 8'h7E;
        TX_SEND = 1'b1;
        @(posedge sysclk);
        #1;
        TX_SEND = 1'b0;
        repeat (79) @(posedge sysclk);
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1 || RX_STATUS !== 1'b0 || RX_DATA !== 8'h00) begin
            bad++;
            $display("FAIL midframe_reset: got tx=%b st=%b rs=%b rd=%h want 1 1 0 00",
                     UART_TX, TX_STATUS, RX_STATUS, RX_DATA);
        end
        last_good = 8'h00;
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        repeat (200) @(negedge sysclk);
        total++;
        if (rx_got.size() != 0 || UART_TX !== 1'b1 || TX_STATUS !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: got %0d pulses tx=%b st=%b want 0 1 1",
                     rx_got.size(), UART_TX, TX_STATUS);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_frames();
        test_tx_busy();
        test_back_to_back();
        test_rx_back_to_back();
        test_rx_errors();
        test_loopback_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
